apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

APB4 master controller that converts a simple valid/ready request/response channel into APB transfers on the master RTL APB interface signals (pselx, penable, paddr, pwrite, pstrb, pwdata, pprot; sampling pready, prdata, pslverr). It sits directly upstream of the master APB interface and is the only driver of its request-side signals. It performs one transfer at a time, decodes the slave select from the upper address bits, and returns read data and error status to the requester.

## Interface
- NO_OF_SLAVES, 1: number of pselx lines; SEL_BITS = (NO_OF_SLAVES>1) ? $clog2(NO_OF_SLAVES) : 0
- ADDRESS_WIDTH, 32: paddr width
- DATA_WIDTH, 32: pwdata/prdata width (8, 16 or 32)
- TIMEOUT_CYCLES, 16: wait-state limit in ACCESS (used only with timeout feature)

Ports:
- pclk  in  1  APB clock; one clock domain, all logic on rising edge
- preset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request
- req_addr  in  ADDRESS_WIDTH  transfer address
- req_write  in  1  1=write, 0=read
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_slverr  out  1  pslverr, decode error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- pselx  out  NO_OF_SLAVES  one-hot slave select
- penable, paddr, pwrite, pstrb, pwdata, pprot  out  per APB4  APB request signals
- pready, prdata, pslverr  in  per APB4  APB completion signals

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- req_ready = (state==IDLE). Handshake req_valid&&req_ready captures all req_* fields.
- Slave index = req_addr[ADDRESS_WIDTH-1 -: SEL_BITS] (0 if SEL_BITS=0). Index < NO_OF_SLAVES: IDLE->SETUP. Index >= NO_OF_SLAVES: IDLE->RESP with rsp_slverr=1, no pselx asserted.
- SETUP: pselx[index]=1, penable=0, paddr/pwrite/pwdata/pprot driven; pstrb=req_strb on writes, 0 on reads. Always ->ACCESS.
- ACCESS: penable=1, all request signals stable. pready=1: capture prdata (reads only) and pslverr, ->RESP. pready=0: stay.
- RESP: rsp_valid=1, pselx=0, penable=0; rsp_* stable until rsp_ready=1, then ->IDLE.
- Outside SETUP/ACCESS, paddr/pwrite/pwdata/pstrb/pprot hold their last values.
- rsp_rdata forced 0 when the transfer is a write or rsp_slverr=1.

## Timing
- Reset (asserted asynchronously, any state): state=IDLE; every output 0, including pselx, penable, paddr, pwrite, pstrb, pwdata, pprot, rsp_*. req_ready=1 after reset deasserts. An in-flight transfer is dropped without a response.
- Accept in cycle N -> SETUP N+1 -> ACCESS N+2; with pready=1 in N+2, rsp_valid in N+3. With rsp_ready=1 in N+3, IDLE in N+4 and the next request is accepted in N+4: minimum 4 cycles per transfer.
- Each wait state (pready=0 in ACCESS) adds one cycle.
- Decode error: accept in N -> rsp_valid in N+1.
- pready is ignored outside ACCESS.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: an 8-bit-or-wider wait counter clears on SETUP->ACCESS and increments on each ACCESS cycle with pready=0. When the count reaches TIMEOUT_CYCLES with pready still 0: ->RESP, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. pselx and penable drop the next cycle. pready=1 in that same cycle wins and completes normally.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied to 0.

## Test plan
- Write, NO_OF_SLAVES=4, addr 0x4000_0010, wdata 0xDEADBEEF, strb 0xF, pready=1 immediately -> pselx=0b0010, SETUP then ACCESS, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
- Read with 3 wait states, prdata=0x1234_5678 -> penable high 4 cycles, pstrb=0, rsp_rdata=0x1234_5678, rsp_valid at accept+6.
- Read returning pslverr=1 with prdata=0xFFFF_FFFF -> rsp_slverr=1, rsp_rdata=0. Hold rsp_ready=0 for 5 cycles -> response stable, req_ready=0 throughout.
- NO_OF_SLAVES=3, addr 0xC000_0000 -> pselx never asserted, rsp_valid at accept+1 with rsp_slverr=1.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 -> rsp_timeout=1, rsp_slverr=1 after 16 wait cycles. Without the macro, the same stimulus leaves the controller in ACCESS.
- preset pulsed while in ACCESS -> all outputs 0 in the same cycle, no response issued, next request proceeds normally.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB4 master controller: valid/ready request/response to APB transfers
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN (wait-state timeout in ACCESS).
//
// Ports:
//   pclk, preset                 clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake; req_addr/write/wdata/strb/prot captured on accept
//   rsp_valid/rsp_ready          response handshake; rsp_rdata/rsp_slverr/rsp_timeout held while valid
//   pselx, penable, paddr,       APB4 request signals (one-hot select decoded from top address bits)
//   pwrite, pstrb, pwdata, pprot
//   pready, prdata, pslverr      APB4 completion signals, sampled only in ACCESS

module apb_master_ctrl #(
    parameter int NO_OF_SLAVES   = 1,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic                      req_write,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [NO_OF_SLAVES-1:0]   pselx,
    output logic                      penable,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic                      pwrite,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int SEL_BITS = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 0;
    localparam int IDX_W    = (SEL_BITS > 0) ? SEL_BITS : 1;

    if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32)) begin : g_bad_param
        $error("apb_master_ctrl: unsupported TIMEOUT_CYCLES or DATA_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   sel_q;
    logic               idx_ok;
    logic               accept;
    logic               timed_out;

    // With a single slave there are no select bits; everything maps to slave 0.
    if (SEL_BITS > 0) begin : g_sel
        assign req_idx = req_addr[ADDRESS_WIDTH-1 -: IDX_W];
    end else begin : g_nosel
        assign req_idx = '0;
    end

    assign idx_ok = (32'(req_idx) < NO_OF_SLAVES);
    assign accept = req_valid && (state == S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // Abort on the cycle that would be the TIMEOUT_CYCLES-th wait state;
    // a pready in that same cycle still completes the transfer normally.
    assign timed_out = (state == S_ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == S_SETUP) begin
            wait_cnt <= '0;
        end else if (state == S_ACCESS && !pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        penable    = 1'b0;
        pselx      = '0;
        case (state)
            S_IDLE: begin
                req_ready = !preset;
                if (req_valid) begin
                    state_next = idx_ok ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                pselx      = NO_OF_SLAVES'(1) << sel_q;
                state_next = S_ACCESS;
            end
            S_ACCESS: begin
                pselx   = NO_OF_SLAVES'(1) << sel_q;
                penable = 1'b1;
                if (pready || timed_out) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // APB request fields load only for decodable requests so they keep their
    // last driven values through IDLE/RESP and across decode errors.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sel_q       <= '0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                if (idx_ok) begin
                    sel_q  <= req_idx;
                    paddr  <= req_addr;
                    pwrite <= req_write;
                    pwdata <= req_wdata;
                    pstrb  <= req_write ? req_strb : '0;
                    pprot  <= req_prot;
                end else begin
                    rsp_rdata   <= '0;
                    rsp_slverr  <= 1'b1;
                    rsp_timeout <= 1'b0;
                end
            end
            if (state == S_ACCESS && (pready || timed_out)) begin
                rsp_slverr  <= pready ? pslverr : 1'b1;
                rsp_timeout <= !pready;
                rsp_rdata   <= (pready && !pwrite && !pslverr) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed scoreboard bench for apb_master_ctrl

module tb_apb_master_ctrl;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [2:0]  pselx;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    apb_master_ctrl #(
        .NO_OF_SLAVES   (3),
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .pselx       (pselx),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pstrb       (pstrb),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   since_acc = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        since_acc++;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic slverr, input logic tmo);
        exp_t e;
        e.rdata  = rdata;
        e.slverr = slverr;
        e.tmo    = tmo;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        req_valid = 1'b1;
        since_acc = 0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int exp_lat);
        exp_t e;
        int   guard = 0;
        while (rsp_valid !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_latency"}, 64'(since_acc), 64'(exp_lat));
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            chk({tag, "_slverr"}, 64'(rsp_slverr), 64'(e.slverr));
            chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.tmo));
        end
        if (rsp_ready) tick();
    endtask

    initial begin
        preset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b1;
        pready    = 1'b1;
        prdata    = '0;
        pslverr   = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_pselx", 64'(pselx), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        preset = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // write to slave 1, zero wait states
        push_exp(32'h0, 1'b0, 1'b0);
        send(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b101);
        chk("wr_setup_pselx", 64'(pselx), 64'b010);
        chk("wr_setup_penable", 64'(penable), 64'd0);
        chk("wr_setup_paddr", 64'(paddr), 64'h4000_0010);
        chk("wr_setup_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        chk("wr_setup_pstrb", 64'(pstrb), 64'hF);
        chk("wr_setup_pwrite", 64'(pwrite), 64'd1);
        chk("wr_setup_pprot", 64'(pprot), 64'b101);
        chk("wr_setup_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("wr_access_penable", 64'(penable), 64'd1);
        chk("wr_access_pselx", 64'(pselx), 64'b010);
        get_rsp("wr", 3);
        chk("wr_idle_req_ready", 64'(req_ready), 64'd1);
        chk("wr_idle_pselx", 64'(pselx), 64'd0);
        chk("wr_idle_paddr_hold", 64'(paddr), 64'h4000_0010);

        // read with 3 wait states
        pready = 1'b0;
        prdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        send(32'h4000_0020, 1'b0, 32'h0, 4'hF, 3'b000);
        chk("rd_setup_pstrb", 64'(pstrb), 64'd0);
        chk("rd_setup_pwrite", 64'(pwrite), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_wait_penable", 64'(penable), 64'd1);
            chk("rd_wait_rsp_valid", 64'(rsp_valid), 64'd0);
            pready = (i == 3);
        end
        get_rsp("rd_wait", 6);
        chk("rd_idle_penable", 64'(penable), 64'd0);

        // read with pslverr, response back-pressured
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hFFFF_FFFF;
        rsp_ready = 1'b0;
        push_exp(32'h0, 1'b1, 1'b0);
        send(32'h4000_0030, 1'b0, 32'h0, 4'h0, 3'b010);
        get_rsp("rd_err", 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_slverr", 64'(rsp_slverr), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'd0);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_pselx", 64'(pselx), 64'd0);
        end
        rsp_ready = 1'b1;
        pslverr   = 1'b0;
        tick();
        chk("hold_release_req_ready", 64'(req_ready), 64'd1);

        // decode error: slave index 3 with only 3 slaves
        push_exp(32'h0, 1'b1, 1'b0);
        send(32'hC000_0000, 1'b1, 32'h5555_5555, 4'hF, 3'b000);
        chk("dec_pselx", 64'(pselx), 64'd0);
        chk("dec_penable", 64'(penable), 64'd0);
        get_rsp("dec", 1);
        chk("dec_paddr_hold", 64'(paddr), 64'h4000_0030);

        // slave never responds
        pready = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        push_exp(32'h0, 1'b1, 1'b1);
        send(32'h0000_0100, 1'b1, 32'h0000_00AA, 4'h1, 3'b000);
        get_rsp("tmo", 18);
        send(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
`else
        send(32'h0000_0100, 1'b1, 32'h0000_00AA, 4'h1, 3'b000);
        for (int i = 0; i < 40; i++) tick();
        chk("stall_penable", 64'(penable), 64'd1);
        chk("stall_pselx", 64'(pselx), 64'b001);
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd0);
`endif

        // asynchronous reset while in ACCESS
        chk("pre_rst_penable", 64'(penable), 64'd1);
        preset = 1'b1;
        #1;
        chk("arst_pselx", 64'(pselx), 64'd0);
        chk("arst_penable", 64'(penable), 64'd0);
        chk("arst_paddr", 64'(paddr), 64'd0);
        chk("arst_pwrite", 64'(pwrite), 64'd0);
        chk("arst_pstrb", 64'(pstrb), 64'd0);
        chk("arst_pwdata", 64'(pwdata), 64'd0);
        chk("arst_pprot", 64'(pprot), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_slverr", 64'(rsp_slverr), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        tick();
        preset = 1'b0;
        pready = 1'b1;
        #1;
        chk("arst_release_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // normal transfer after reset
        push_exp(32'h0, 1'b0, 1'b0);
        send(32'h8000_0004, 1'b1, 32'hA5A5_0001, 4'b0011, 3'b001);
        chk("post_setup_pselx", 64'(pselx), 64'b100);
        chk("post_setup_pstrb", 64'(pstrb), 64'b0011);
        chk("post_setup_paddr", 64'(paddr), 64'h8000_0004);
        get_rsp("post", 3);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
